// File: rtl/tff_chain_if.sv
`default_nettype none
// ============================================================================
// Module      : tff_chain_if
// Description : Control/data bundle for tff_chain. The master drives the
//               controls and lane data, the slave returns the stage outputs.
//               toggle_cnt exists only when TFF_CHAIN_TCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface tff_chain_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             mode;
    logic [WIDTH-1:0] data;
    logic [TAP_W-1:0] tap_sel;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_tap;
    logic             q_valid;

    if (WIDTH < 1 || DEPTH < 1 || TAP_W < 1 || CNT_W < 1) begin : g_param_check
        $error("tff_chain_if: WIDTH, DEPTH, TAP_W and CNT_W must all be >= 1");
    end

`ifdef TFF_CHAIN_TCNT_EN
    logic [CNT_W-1:0] toggle_cnt;

    modport master (output en, clr, mode, data, tap_sel,
                    input  q, q_tap, q_valid, toggle_cnt);
    modport slave  (input  en, clr, mode, data, tap_sel,
                    output q, q_tap, q_valid, toggle_cnt);
`else
    modport master (output en, clr, mode, data, tap_sel,
                    input  q, q_tap, q_valid);
    modport slave  (input  en, clr, mode, data, tap_sel,
                    output q, q_tap, q_valid);
`endif
endinterface
`default_nettype wire

// File: rtl/tff_chain.sv
`default_nettype none
// ============================================================================
// Module      : tff_chain
// Description : WIDTH lanes of DEPTH-stage toggle (T-FF) or delay (D shift)
//               cascade with enable, sync clear, fill-valid flag and stage tap.
//               Optional toggle counter on q enabled by TFF_CHAIN_TCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tff_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    tff_chain_if.slave bus
);
    localparam int                FILL_W   = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  stage_d [DEPTH];
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              valid_q;
    logic [WIDTH-1:0]  tap_mux;

    if (WIDTH < 1 || DEPTH < 1 || TAP_W < 1 || CNT_W < 1) begin : g_param_check
        $error("tff_chain: WIDTH, DEPTH, TAP_W and CNT_W must all be >= 1");
    end

    // Each stage is fed by its predecessor's old value; stage 0 by lane data.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] src;
        if (k == 0) begin : g_head
            assign src = bus.data;
        end else begin : g_link
            assign src = stage_q[k-1];
        end
        assign stage_d[k] = bus.mode ? src : (stage_q[k] ^ src);
    end

    assign fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.clr) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.en) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
            fill_q  <= fill_d;
            valid_q <= (fill_d == FILL_MAX);
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        tap_mux = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (32'(bus.tap_sel) == k) tap_mux = stage_q[k];
        end
    end

    assign bus.q       = stage_q[DEPTH-1];
    assign bus.q_tap   = tap_mux;
    assign bus.q_valid = valid_q;

`ifdef TFF_CHAIN_TCNT_EN
    logic [WIDTH-1:0] q_prev_q;
    logic [CNT_W-1:0] tcnt_q;

    // A change on q is counted one enabled edge after it becomes visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_prev_q <= '0;
            tcnt_q   <= '0;
        end else if (bus.clr) begin
            q_prev_q <= '0;
            tcnt_q   <= '0;
        end else if (bus.en) begin
            q_prev_q <= stage_q[DEPTH-1];
            if ((stage_q[DEPTH-1] != q_prev_q) && (tcnt_q != '1)) begin
                tcnt_q <= tcnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.toggle_cnt = tcnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_tff_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_tff_chain
// Description : Self-checking bench: vector table, hand sequences and random
//               stimulus against a reference model for tff_chain.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tff_chain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    tff_chain_if #(.WIDTH(4), .DEPTH(3)) a_if ();
    tff_chain_if #(.WIDTH(1), .DEPTH(2)) b_if ();

    tff_chain #(.WIDTH(4), .DEPTH(3)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    tff_chain #(.WIDTH(1), .DEPTH(2)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

`ifdef TFF_CHAIN_TCNT_EN
    tff_chain_if #(.WIDTH(1), .DEPTH(1), .CNT_W(2)) c_if ();
    tff_chain #(.WIDTH(1), .DEPTH(1), .CNT_W(2)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model for lane bank A: stage values and fill count.
    logic [3:0] m_s [3];
    int         m_fill;

    task automatic mdl_reset();
        for (int k = 0; k < 3; k++) m_s[k] = 4'h0;
        m_fill = 0;
    endtask

    task automatic mdl_edge();
        logic [3:0] prev [3];
        logic [3:0] up;
        if (a_if.clr) begin
            mdl_reset();
        end else if (a_if.en) begin
            prev = m_s;
            for (int k = 0; k < 3; k++) begin
                up     = (k == 0) ? a_if.data : prev[k-1];
                m_s[k] = a_if.mode ? up : (prev[k] ^ up);
            end
            m_fill = (m_fill < 3) ? m_fill + 1 : 3;
        end
    endtask

    task automatic mdl_check(input string name);
        logic [3:0] etap;
        etap = (a_if.tap_sel < 2'd3) ? m_s[a_if.tap_sel] : 4'h0;
        chk({name, ".q"},     32'(a_if.q),       32'(m_s[2]));
        chk({name, ".tap"},   32'(a_if.q_tap),   32'(etap));
        chk({name, ".valid"}, 32'(a_if.q_valid), 32'(m_fill == 3));
    endtask

    typedef struct {
        logic       en;
        logic       clr;
        logic       mode;
        logic [3:0] data;
        logic [1:0] tap;
        logic [3:0] eq;
        logic [3:0] etap;
        logic       ev;
    } vec_t;

    vec_t tbl [14];
    logic b_exp [8];
`ifdef TFF_CHAIN_TCNT_EN
    logic [1:0] c_exp [6];
`endif

    initial begin
        // en clr mode data tap | q tap valid
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'hA, 2'd1, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'h0, 2'd1, 4'h0, 4'hA, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'h0, 2'd3, 4'hA, 4'h0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'h0, 2'd2, 4'h0, 4'h0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'h7, 2'd2, 4'h0, 4'h0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'hF, 2'd0, 4'h0, 4'hF, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 4'h0, 4'hF, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 4'h0, 4'hF, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'h0, 2'd1, 4'h0, 4'hF, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 4'h0, 2'd2, 4'hF, 4'hF, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd2, 4'hF, 4'hF, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 4'h5, 2'd2, 4'hF, 4'hF, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 4'hF, 4'h5, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 4'h0, 2'd1, 4'h5, 4'h5, 1'b1};
        b_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        {a_if.en, a_if.clr, a_if.mode, a_if.data, a_if.tap_sel} = '0;
        {b_if.en, b_if.clr, b_if.mode, b_if.data, b_if.tap_sel} = '0;
`ifdef TFF_CHAIN_TCNT_EN
        {c_if.en, c_if.clr, c_if.mode, c_if.data, c_if.tap_sel} = '0;
        c_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`endif
        mdl_reset();

        // Reset state, with a clock edge seen while reset is held.
        a_if.en = 1'b1; a_if.data = 4'hF;
        #17;
        chk("rst.q",     32'(a_if.q),       32'h0);
        chk("rst.tap",   32'(a_if.q_tap),   32'h0);
        chk("rst.valid", 32'(a_if.q_valid), 32'h0);
        a_if.en = 1'b0; a_if.data = 4'h0;
        #5 rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            a_if.en = tbl[i].en; a_if.clr = tbl[i].clr; a_if.mode = tbl[i].mode;
            a_if.data = tbl[i].data; a_if.tap_sel = tbl[i].tap;
            mdl_edge();
            @(posedge clk); #1;
            chk($sformatf("tbl%0d.q", i),     32'(a_if.q),       32'(tbl[i].eq));
            chk($sformatf("tbl%0d.tap", i),   32'(a_if.q_tap),   32'(tbl[i].etap));
            chk($sformatf("tbl%0d.valid", i), 32'(a_if.q_valid), 32'(tbl[i].ev));
        end

        // Two-stage toggle cascade on lane bank B.
        a_if.en = 1'b0;
        b_if.en = 1'b1; b_if.mode = 1'b0; b_if.data = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("tog%0d.q", i),     32'(b_if.q),       32'(b_exp[i]));
            chk($sformatf("tog%0d.valid", i), 32'(b_if.q_valid), 32'(i >= 1));
        end
        b_if.en = 1'b0;

        // Asynchronous reset between edges clears outputs without a clock.
        a_if.en = 1'b1; a_if.mode = 1'b1; a_if.data = 4'hF; a_if.tap_sel = 2'd0;
        repeat (3) begin
            mdl_edge();
            @(posedge clk); #1;
        end
        mdl_check("prerst");
        #2 rst = 1'b1;
        #1;
        chk("arst.q",     32'(a_if.q),       32'h0);
        chk("arst.tap",   32'(a_if.q_tap),   32'h0);
        chk("arst.valid", 32'(a_if.q_valid), 32'h0);
        mdl_reset();
        #1 rst = 1'b0;

        for (int i = 0; i < 600; i++) begin
            a_if.en      = ($urandom_range(0, 3) != 0);
            a_if.clr     = ($urandom_range(0, 24) == 0);
            a_if.mode    = 1'($urandom_range(0, 1));
            a_if.data    = 4'($urandom_range(0, 15));
            a_if.tap_sel = 2'($urandom_range(0, 3));
            mdl_edge();
            @(posedge clk); #1;
            mdl_check($sformatf("rnd%0d", i));
            if ($urandom_range(0, 39) == 0) begin
                #1 rst = 1'b1;
                #1;
                chk($sformatf("rnd%0d.arst", i), 32'(a_if.q), 32'h0);
                mdl_reset();
                #1 rst = 1'b0;
            end
        end
        a_if.en = 1'b0; a_if.clr = 1'b0;

`ifdef TFF_CHAIN_TCNT_EN
        c_if.en = 1'b1; c_if.mode = 1'b0; c_if.data = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("tcnt%0d.q", i),   32'(c_if.q),          32'(i % 2 == 0));
            chk($sformatf("tcnt%0d.cnt", i), 32'(c_if.toggle_cnt), 32'(c_exp[i]));
        end
        c_if.clr = 1'b1;
        @(posedge clk); #1;
        chk("tcnt.clr.cnt", 32'(c_if.toggle_cnt), 32'h0);
        chk("tcnt.clr.q",   32'(c_if.q),          32'h0);
        c_if.clr = 1'b0; c_if.en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tff_chain.md
Name: tff_chain

Overview:
- Parametrised successor to the team's fixed two-stage toggle flip-flop cascade.
- Provides WIDTH independent lanes, each a DEPTH-stage cascade.
- Runtime mode select: toggle (T-FF cascade) or plain delay (D shift).
- Adds clock enable, synchronous clear, a fill-valid flag and a selectable stage tap; used as a configurable toggle/divide/delay primitive in the training-block library.

Parameters:
- WIDTH, 1, number of independent lanes (bits per stage), >=1
- DEPTH, 2, number of cascaded stages per lane, >=1
- TAP_W, (DEPTH>1 ? $clog2(DEPTH) : 1), width of tap_sel; derived, not overridden
- CNT_W, 8, width of optional toggle counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  stage-advance enable; 0 = all state holds
- clr  input  1  synchronous clear of stages and fill count
- mode  input  1  0 = toggle cascade, 1 = delay cascade
- data  input  WIDTH  lane inputs to stage 0
- tap_sel  input  TAP_W  selects stage driven on q_tap
- q  output  WIDTH  stage DEPTH-1 (registered)
- q_tap  output  WIDTH  stage tap_sel (combinational mux of registered stages)
- q_valid  output  1  registered; 1 once DEPTH enabled cycles have elapsed since reset/clear
- toggle_cnt  output  CNT_W  present only with TFF_CHAIN_TCNT_EN

Behaviour:
- State: s[0..DEPTH-1], each WIDTH bits; fill counter 0..DEPTH.
- Priority: rst > clr > en.
- rst=1 (async): all s[k]=0, fill=0, q=0, q_valid=0, toggle_cnt=0. Holds while rst high; release takes effect at the next rising edge.
- clr=1 at an edge: same values as reset, applied synchronously, regardless of en or mode.
- en=0, clr=0: all state holds, including fill and counter.
- en=1, mode=0 (toggle), per lane, bitwise:
  - s[0] <= s[0] ^ data
  - s[k] <= s[k] ^ s[k-1] (old value), k>=1
- en=1, mode=1 (delay):
  - s[0] <= data
  - s[k] <= s[k-1] (old value)
- DEPTH=1: only stage 0 exists; q = s[0].
- Latency, delay mode: data sampled at edge n appears on q after edge n+DEPTH-1 (DEPTH edges including the sampling edge).
- Fill counter: increments on each enabled, non-cleared edge; saturates at DEPTH. q_valid = (fill==DEPTH), registered alongside fill.
- Mode change: no flush; takes effect at the next enabled edge; fill and q_valid unaffected.
- tap_sel >= DEPTH: q_tap = 0. tap_sel = DEPTH-1: q_tap equals q.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro TFF_CHAIN_TCNT_EN.
- Defined:
  - Port toggle_cnt exists.
  - Counts edges at which q changed value (any lane bit differs from its previous registered value).
  - Saturates at 2^CNT_W-1; cleared by rst and clr; holds when en=0.
  - Increments in the cycle after the q change is visible (compares current q with a registered copy).
- Undefined: port and all counter logic absent; remaining behaviour identical.

Test Plan:
- WIDTH=1, DEPTH=2, mode=0, en=1, data=1 held from reset release -> q across edges 1..8 = 0,1,1,0,0,1,1,0; q_valid=1 from edge 2.
- WIDTH=4, DEPTH=3, mode=1, data=0xA for one edge then 0 -> q=0xA only after the 3rd edge, 0 otherwise; q_tap with tap_sel=1 shows 0xA after the 2nd edge; tap_sel=3 -> q_tap=0.
- Delay mode, en toggled 1,0,0,1,1 with data=0xF on first edge -> fill reaches 3 only after the 3rd enabled edge; 0xF reaches q then; stages hold across en=0 cycles.
- Mid-stream clr=1 for one edge with en=1 -> all stages 0, q_valid=0 next cycle; refill takes DEPTH enabled edges. rst pulsed between edges -> q=0 immediately, without waiting for a clock.
- Toggle mode running, switch mode to 1 with data=0 -> the next enabled edge shifts (s[1]<=old s[0]); q_valid stays 1.
- With TFF_CHAIN_TCNT_EN, CNT_W=2, DEPTH=1, mode=0, data=1 -> q toggles every edge; toggle_cnt = 1,2,3,3,3 (saturates); clr returns it to 0.
